// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares a single-port data memory between N_REQ requesters
//                (fixed priority, starvation override, atomic bus lock)
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int N_REQ        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       m_valid,
  output logic [N_REQ-1:0]       m_ready,
  input  logic [N_REQ-1:0]       m_we,
  input  logic [N_REQ-1:0]       m_lock,
  input  logic [N_REQ-1:0][31:0] m_addr,
  input  logic [N_REQ-1:0][3:0]  m_be,
  input  logic [N_REQ-1:0][31:0] m_wdata,
  output logic [N_REQ-1:0]       r_valid,
  output logic [31:0]            r_rdata,
  output logic [31:0]            mem_addr,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int LC_W  = $clog2(LOCK_MAX + 1);

  localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [LC_W-1:0] C_LOCK_MAX   = LC_W'(LOCK_MAX);
  localparam logic [LC_W-1:0] C_LOCK_ONE   = LC_W'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            owner_q, owner_d;
  logic [LC_W-1:0]             lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0][SC_W-1:0]  starve_q, starve_d;
  logic [N_REQ-1:0]            r_valid_q, r_valid_d;
  logic [31:0]                 r_rdata_q, r_rdata_d;
  logic [31:0]                 addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [3:0]                  be_q, be_d;

  logic                        grant_any;
  logic [IDX_W-1:0]            win;
  logic [N_REQ-1:0]            grant;

  // Winner selection; the lock owner excludes everyone else even when idle.
  always_comb begin
    grant_any = 1'b0;
    win       = '0;
    if (state_q == S_LOCKED) begin
      grant_any = m_valid[owner_q];
      win       = owner_q;
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (m_valid[i]) begin
          grant_any = 1'b1;
          win       = IDX_W'(i);
        end
      end
      // A starved requester overrides plain priority; lowest starved index wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (m_valid[i] && (starve_q[i] == C_STARVE_MAX)) begin
          win = IDX_W'(i);
        end
      end
    end
    if (!rst) begin
      grant_any = 1'b0;
    end
  end

  assign grant   = grant_any ? (N_REQ'(1) << win) : '0;
  assign m_ready = grant;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = wdata_q;
    if (grant_any) begin
      mem_we    = m_we[win];
      mem_addr  = m_addr[win];
      mem_be    = m_be[win];
      mem_wdata = m_wdata[win];
    end
    addr_d  = mem_addr;
    be_d    = mem_be;
    wdata_d = mem_wdata;
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      starve_d[i] = '0;
      if (m_valid[i] && !grant[i]) begin
        starve_d[i] = (starve_q[i] == C_STARVE_MAX) ? C_STARVE_MAX : starve_q[i] + SC_W'(1);
      end
    end
  end

  always_comb begin
    r_valid_d = grant;
    r_rdata_d = r_rdata_q;
    if (grant_any && !m_we[win]) begin
      r_rdata_d = mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any && m_lock[win]) begin
          state_d    = S_LOCKED;
          owner_d    = win;
          lock_cnt_d = C_LOCK_ONE;
        end
      end
      S_LOCKED: begin
        if (grant_any && !m_lock[win]) begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end else begin
          // Counts idle cycles of the owner too, so a stalled owner cannot hold the bus forever.
          lock_cnt_d = lock_cnt_q + C_LOCK_ONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
      end
    endcase
    if ((state_d == S_LOCKED) && (lock_cnt_d >= C_LOCK_MAX)) begin
      state_d    = S_IDLE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      starve_q   <= '0;
      r_valid_q  <= '0;
      r_rdata_q  <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      starve_q   <= starve_d;
      r_valid_q  <= r_valid_d;
      r_rdata_q  <= r_rdata_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Randomized bench for dmem_arbiter: requesters, memory and a rule-level reference
// model; responses are checked from a scoreboard queue by an independent monitor.
module tb_dmem_arbiter;

  localparam int N    = 3;
  localparam int SL   = 4;
  localparam int LM   = 8;
  localparam int NCYC = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      m_valid = '0;
  logic [N-1:0]      m_ready;
  logic [N-1:0]      m_we = '0;
  logic [N-1:0]      m_lock = '0;
  logic [N-1:0][31:0] m_addr = '0;
  logic [N-1:0][3:0] m_be = '0;
  logic [N-1:0][31:0] m_wdata = '0;
  logic [N-1:0]      r_valid;
  logic [31:0]       r_rdata;
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  dmem_arbiter #(.N_REQ(N), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .r_valid(r_valid), .r_rdata(r_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5C30F96;
  endfunction

  // Memory seen by the DUT (combinational read, byte-enabled write)
  logic        mem_init = 1'b1;
  logic [31:0] dut_mem [64];
  assign mem_rdata = dut_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dut_mem[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dut_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          req;
    logic [31:0] data;
    int          cyc;
  } rsp_t;
  rsp_t q[$];
  rsp_t e;

  // Monitor: pops the scoreboard whenever a response appears or is overdue
  always @(negedge clk) begin
    if (rst) begin
      if (r_valid != '0) begin
        if (q.size() == 0) begin
          check("unexpected_rvalid", 32'(r_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("rsp_valid", 32'(r_valid), 32'(1) << e.req);
          check("rsp_data", r_rdata, e.data);
          check("rsp_latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("rsp_missing", 32'(r_valid), 32'(1) << e.req);
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          starve [N];
  int          lk_own;
  int          lk_cnt;
  logic [31:0] exp_rd;
  int          lock_left [N];
  int          prob [N];

  task automatic check_reset_outputs();
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_rdata", r_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) starve[i] = 0;
    lk_own = -1;
    lk_cnt = 0;
    exp_rd = '0;
  endtask

  initial begin
    int   last_win;
    int   win;
    bit   did_rst;
    logic [31:0] w;

    prob[0] = 80; prob[1] = 50; prob[2] = 40;
    for (int i = 0; i < N; i++) lock_left[i] = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    last_win = -1;
    did_rst  = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    mem_init = 1'b0;
    rst      = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (last_win >= 0) m_valid[last_win] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!m_valid[i] && $urandom_range(99) < prob[i]) begin
          m_valid[i] = 1'b1;
          m_we[i]    = 1'($urandom_range(1));
          m_addr[i]  = 32'($urandom_range(255));
          m_be[i]    = 4'($urandom_range(15));
          m_wdata[i] = $urandom;
          if (lock_left[i] > 0) begin
            m_lock[i] = (lock_left[i] > 1);
            lock_left[i]--;
          end else if ($urandom_range(9) == 0) begin
            lock_left[i] = $urandom_range(12, 2) - 1;
            m_lock[i]    = 1'b1;
          end else begin
            m_lock[i] = 1'b0;
          end
        end
      end
      last_win = -1;

      // Asynchronous reset in the middle of a lock with a response in flight
      if (!did_rst && c >= NCYC / 2 && lk_own >= 0) begin
        rst = 1'b0;
        q.delete();
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        did_rst = 1;
      end

      @(negedge clk);
      win = -1;
      if (lk_own >= 0) begin
        if (m_valid[lk_own]) win = lk_own;
      end else begin
        for (int i = 0; i < N; i++)
          if (win < 0 && m_valid[i] && starve[i] >= SL) win = i;
        for (int i = 0; i < N; i++)
          if (win < 0 && m_valid[i]) win = i;
      end

      check("m_ready", 32'(m_ready), (win >= 0) ? (32'(1) << win) : 32'd0);
      if (win >= 0) begin
        check("mem_we", 32'(mem_we), 32'(m_we[win]));
        check("mem_addr", mem_addr, m_addr[win]);
        if (m_we[win]) begin
          check("mem_be", 32'(mem_be), 32'(m_be[win]));
          check("mem_wdata", mem_wdata, m_wdata[win]);
          w = ref_mem[m_addr[win][7:2]];
          for (int b = 0; b < 4; b++)
            if (m_be[win][b]) w[8*b +: 8] = m_wdata[win][8*b +: 8];
          ref_mem[m_addr[win][7:2]] = w;
        end else begin
          exp_rd = ref_mem[m_addr[win][7:2]];
        end
        q.push_back('{req: win, data: exp_rd, cyc: cyc + 1});
      end else begin
        check("mem_we_idle", 32'(mem_we), 32'd0);
      end

      for (int i = 0; i < N; i++)
        starve[i] = (m_valid[i] && i != win) ? ((starve[i] < SL) ? starve[i] + 1 : SL) : 0;

      if (lk_own >= 0) begin
        if (win == lk_own && !m_lock[win]) begin
          lk_own = -1;
        end else begin
          lk_cnt++;
          if (lk_cnt >= LM) lk_own = -1;
        end
      end else if (win >= 0 && m_lock[win]) begin
        lk_own = win;
        lk_cnt = 1;
        if (lk_cnt >= LM) lk_own = -1;
      end
      last_win = win;
    end

    @(posedge clk);
    #1;
    m_valid = '0;
    repeat (3) @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    for (int i = 0; i < 64; i++) check("mem_word", dut_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
